// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one combinational ALU between two requesters.
// Rev 1.0 - initial release.
`default_nettype none

module alu_share_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] C_NOP      = 4'b1111;
  localparam logic [3:0] C_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q;
  logic             last_q;
  logic [3:0]       cnt_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;

  logic             w_grant;
  logic             w_accept;
  logic [3:0]       w_ctrl;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111: is_legal = 1'b1;
      default:                                                       is_legal = 1'b0;
    endcase
  endfunction

  // A lone requester wins outright; on a tie (or no request) the one not served last is granted.
  always_comb begin
    if (req0_valid && !req1_valid)      w_grant = 1'b0;
    else if (req1_valid && !req0_valid) w_grant = 1'b1;
    else                                w_grant = ~last_q;
  end

  assign w_accept   = (state_q == S_IDLE) && (w_grant ? req1_valid : req0_valid);
  assign w_ctrl     = w_grant ? req1_ctrl : req0_ctrl;
  assign w_a        = w_grant ? req1_a    : req0_a;
  assign w_b        = w_grant ? req1_b    : req0_b;

  assign req0_ready = (state_q == S_IDLE) && !w_grant;
  assign req1_ready = (state_q == S_IDLE) &&  w_grant;

  assign alu_ctrl   = (state_q == S_EXEC) ? ctrl_q : C_NOP;
  assign alu_data1  = (state_q == S_EXEC) ? a_q    : '0;
  assign alu_data2  = (state_q == S_EXEC) ? b_q    : '0;

  assign resp_valid  = (state_q == S_RESP);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
      ctrl_q   <= C_NOP;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            id_q <= w_grant;
            if (is_legal(w_ctrl)) begin
              ctrl_q  <= w_ctrl;
              a_q     <= w_a;
              b_q     <= w_b;
              last_q  <= w_grant;
              cnt_q   <= C_CNT_LOAD;
              state_q <= S_EXEC;
            end else begin
              // Illegal op never reaches the ALU; answer immediately with an error.
              result_q <= '0;
              zero_q   <= 1'b0;
              err_q    <= 1'b1;
              state_q  <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == 4'd0) begin
            result_q <= alu_result;
            zero_q   <= alu_zero;
            err_q    <= 1'b0;
            state_q  <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of alu_share_ctrl with settle times of 1 and 3 cycles.
// Rev 1.0 - initial release.
`default_nettype none

module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: alu_model = a & b;
      4'b0001: alu_model = a | b;
      4'b0010: alu_model = a + b;
      4'b0110: alu_model = a - b;
      4'b0111: alu_model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: alu_model = a ^ b;
      default: alu_model = 32'd0;
    endcase
  endfunction

  // Instance with SETTLE_CYCLES=1
  logic        a0v = 0, a1v = 0, a0r, a1r, arr = 1;
  logic [3:0]  a0c = 0, a1c = 0, actl;
  logic [31:0] a0a = 0, a0b = 0, a1a = 0, a1b = 0;
  logic        avld, aid, azero, aerr, abusy;
  logic [31:0] ares, ad1, ad2, aalu;
  assign aalu = alu_model(actl, ad1, ad2);

  alu_share_ctrl #(.WIDTH(32), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst),
    .req0_valid(a0v), .req0_ready(a0r), .req0_ctrl(a0c), .req0_a(a0a), .req0_b(a0b),
    .req1_valid(a1v), .req1_ready(a1r), .req1_ctrl(a1c), .req1_a(a1a), .req1_b(a1b),
    .resp_valid(avld), .resp_ready(arr), .resp_id(aid), .resp_result(ares),
    .resp_zero(azero), .resp_err(aerr),
    .alu_data1(ad1), .alu_data2(ad2), .alu_ctrl(actl),
    .alu_result(aalu), .alu_zero(aalu == 32'd0), .busy(abusy)
  );

  // Instance with SETTLE_CYCLES=3
  logic        b0v = 0, b1v = 0, b0r, b1r, brr = 0;
  logic [3:0]  b0c = 0, b1c = 0, bctl;
  logic [31:0] b0a = 0, b0b = 0, b1a = 0, b1b = 0;
  logic        bvld, bid, bzero, berr, bbusy;
  logic [31:0] bres, bd1, bd2, balu;
  assign balu = alu_model(bctl, bd1, bd2);

  alu_share_ctrl #(.WIDTH(32), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst),
    .req0_valid(b0v), .req0_ready(b0r), .req0_ctrl(b0c), .req0_a(b0a), .req0_b(b0b),
    .req1_valid(b1v), .req1_ready(b1r), .req1_ctrl(b1c), .req1_a(b1a), .req1_b(b1b),
    .resp_valid(bvld), .resp_ready(brr), .resp_id(bid), .resp_result(bres),
    .resp_zero(bzero), .resp_err(berr),
    .alu_data1(bd1), .alu_data2(bd2), .alu_ctrl(bctl),
    .alu_result(balu), .alu_zero(balu == 32'd0), .busy(bbusy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Single-requester legal op on the SETTLE_CYCLES=1 instance with resp_ready held high.
  task automatic run1(input logic id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input logic exp_zero);
    if (id) begin a1v = 1; a1c = c; a1a = a; a1b = b; end
    else    begin a0v = 1; a0c = c; a0a = a; a0b = b; end
    #1;
    chk("run1_ready", id ? a1r : a0r, 1);
    tick();
    a0v = 0; a1v = 0;
    chk("run1_alu_ctrl", actl, c);
    tick();
    chk("run1_valid", avld, 1);
    chk("run1_id", aid, id);
    chk("run1_result", ares, exp_res);
    chk("run1_zero", azero, exp_zero);
    chk("run1_err", aerr, 0);
    tick();
    chk("run1_idle", avld, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    chk("rst_valid", avld, 0);
    chk("rst_busy", abusy, 0);
    chk("rst_alu_ctrl", actl, 4'hF);
    chk("rst_data1", ad1, 0);
    chk("rst_data2", ad2, 0);
    chk("rst_result", ares, 0);
    chk("rst_id", aid, 0);
    chk("rst_err", aerr, 0);

    // ADD 3+4 from req0
    rst = 0;
    a0v = 1; a0c = 4'b0010; a0a = 3; a0b = 4;
    #1;
    chk("add_ready0", a0r, 1);
    chk("add_ready1", a1r, 0);
    chk("add_pre_ctrl", actl, 4'hF);
    tick();
    a0v = 0;
    chk("add_exec_ctrl", actl, 4'b0010);
    chk("add_exec_d1", ad1, 3);
    chk("add_exec_d2", ad2, 4);
    chk("add_exec_busy", abusy, 1);
    chk("add_exec_ready0", a0r, 0);
    chk("add_exec_valid", avld, 0);
    tick();
    chk("add_resp_valid", avld, 1);
    chk("add_resp_id", aid, 0);
    chk("add_resp_result", ares, 7);
    chk("add_resp_zero", azero, 0);
    chk("add_resp_err", aerr, 0);
    chk("add_resp_ctrl", actl, 4'hF);
    tick();
    chk("add_done_valid", avld, 0);
    chk("add_done_busy", abusy, 0);

    run1(1, 4'b0110, 9, 9, 0, 1);
    run1(1, 4'b0111, 5, 7, 1, 0);

    // Round-robin: req0 ADD 1+1 twice, req1 XOR F0^0F twice, both held valid
    a0v = 1; a0c = 4'b0010; a0a = 1;     a0b = 1;
    a1v = 1; a1c = 4'b1100; a1a = 32'hF0; a1b = 32'h0F;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", a0r, (k % 2 == 0) ? 1 : 0);
      chk("rr_ready1", a1r, (k % 2 == 1) ? 1 : 0);
      tick();
      if (k == 2) a0v = 0;
      if (k == 3) a1v = 0;
      tick();
      chk("rr_valid", avld, 1);
      chk("rr_id", aid, (k % 2 == 1) ? 1 : 0);
      chk("rr_result", ares, (k % 2 == 1) ? 32'hFF : 32'h2);
      tick();
    end

    // Illegal op code 0011
    a0v = 1; a0c = 4'b0011; a0a = 1; a0b = 1;
    #1;
    chk("ill_ready0", a0r, 1);
    chk("ill_pre_ctrl", actl, 4'hF);
    tick();
    a0v = 0;
    chk("ill_valid", avld, 1);
    chk("ill_err", aerr, 1);
    chk("ill_result", ares, 0);
    chk("ill_zero", azero, 0);
    chk("ill_id", aid, 0);
    chk("ill_ctrl", actl, 4'hF);
    tick();
    chk("ill_done", avld, 0);
    chk("ill_post_ctrl", actl, 4'hF);

    // SETTLE_CYCLES=3: OR 0xA|0x5 with a 5-cycle response stall
    b0v = 1; b0c = 4'b0001; b0a = 32'hA; b0b = 32'h5;
    #1;
    chk("set_ready0", b0r, 1);
    tick();
    b0v = 0;
    for (int i = 0; i < 3; i++) begin
      chk("set_exec_ctrl", bctl, 4'b0001);
      chk("set_exec_d1", bd1, 32'hA);
      chk("set_exec_d2", bd2, 32'h5);
      chk("set_exec_valid", bvld, 0);
      tick();
    end
    chk("set_post_ctrl", bctl, 4'hF);
    b0v = 1; b1v = 1; b1c = 4'b0010;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", bvld, 1);
      chk("stall_result", bres, 32'hF);
      chk("stall_zero", bzero, 0);
      chk("stall_id", bid, 0);
      chk("stall_busy", bbusy, 1);
      chk("stall_ready0", b0r, 0);
      chk("stall_ready1", b1r, 0);
      tick();
    end
    brr = 1;
    tick();
    brr = 0;
    chk("stall_done_valid", bvld, 0);
    chk("stall_done_busy", bbusy, 0);
    chk("stall_tie_ready1", b1r, 1);
    chk("stall_tie_ready0", b0r, 0);
    b0v = 0; b1v = 0;

    // Reset during the second EXEC cycle discards the op
    b0v = 1; b0c = 4'b0010; b0a = 5; b0b = 5;
    #1;
    chk("rx_ready0", b0r, 1);
    tick();
    b0v = 0;
    chk("rx_exec1_ctrl", bctl, 4'b0010);
    tick();
    chk("rx_exec2_ctrl", bctl, 4'b0010);
    rst = 1;
    tick();
    rst = 0;
    chk("rx_busy", bbusy, 0);
    chk("rx_valid", bvld, 0);
    chk("rx_ctrl", bctl, 4'hF);
    chk("rx_d1", bd1, 0);
    chk("rx_result", bres, 0);
    chk("rx_id", bid, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rx_no_resp", bvld, 0);
      tick();
    end
    b0v = 1; b0c = 4'b0010; b0a = 2; b0b = 2;
    b1v = 1; b1c = 4'b0000; b1a = 1; b1b = 1;
    #1;
    chk("rx_tie_ready0", b0r, 1);
    chk("rx_tie_ready1", b1r, 0);
    brr = 1;
    tick();
    b0v = 0;
    tick(); tick(); tick();
    chk("rx_new_valid", bvld, 1);
    chk("rx_new_id", bid, 0);
    chk("rx_new_result", bres, 4);
    chk("rx_new_zero", bzero, 0);
    tick();
    b1v = 0;
    chk("rx_new_done", bvld, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter that shares one combinational ALU (AND/OR/ADD/SUB/SLT/XOR/NOP, 4-bit op code, 32-bit operands, zero flag) between two requesters. Example requesters are the main execute stage and an address/branch unit. It does four things:
- arbitrates round-robin between the requesters;
- drives the ALU operand and op ports from registers and holds them for a programmable settle time;
- captures the result and zero flag;
- returns them on a single valid/ready response channel tagged with the requester ID.

Illegal op codes are rejected without driving the ALU.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- SETTLE_CYCLES, 1, cycles ALU ports are held before capture; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_ctrl / req1_ctrl  in  4  ALU op code
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester that issued the op
- resp_result  out  WIDTH  captured ALU result
- resp_zero  out  1  captured ALU zero flag
- resp_err  out  1  op code was illegal
- alu_data1, alu_data2  out  WIDTH  to ALU operands
- alu_ctrl  out  4  to ALU op select
- alu_result  in  WIDTH  from ALU
- alu_zero  in  1  from ALU
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, RESP.
- Legal codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 XOR, 1111 NOP. All other codes are illegal.
- Grant in IDLE:
  - only one requester valid: that one wins;
  - both valid: the one not served last wins;
  - last-served pointer resets to 1, so requester 0 wins the first tie.
- reqN_ready = (state==IDLE) && grant==N. reqN_ready is 0 in EXEC and RESP.
- Accept (legal code): register ctrl/a/b and id, update last-served pointer, load settle counter with SETTLE_CYCLES-1, go to EXEC.
- Accept (illegal code): go straight to RESP with resp_err=1, resp_result=0, resp_zero=0. The ALU ports are not driven, so alu_ctrl stays 1111.
- EXEC:
  - alu_ctrl/alu_data1/alu_data2 come from the operand registers and are stable every EXEC cycle;
  - counter decrements each cycle;
  - on the edge where the counter is 0: capture alu_result → resp_result and alu_zero → resp_zero, set resp_err=0, go to RESP.
- RESP:
  - resp_valid=1;
  - resp_id/result/zero/err are held stable until resp_valid&resp_ready;
  - on that edge, go to IDLE.
- Outside EXEC: alu_ctrl=1111 (NOP), alu_data1=alu_data2=0.
- Requests are not queued. A requester not granted keeps valid asserted; dropping valid before acceptance is permitted and has no side effect.

## Timing
- Reset values:
  - state IDLE, last-served=1, counter=0;
  - resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, resp_err=0, busy=0;
  - alu_ctrl=1111, alu_data1=alu_data2=0;
  - req0_ready/req1_ready follow the IDLE grant rule from the first cycle after reset deasserts.
- Legal op accepted at edge E:
  - ALU ports are driven in cycles E+1 .. E+SETTLE_CYCLES;
  - capture happens at edge E+SETTLE_CYCLES;
  - resp_valid=1 from the following cycle.
- Illegal op accepted at edge E: resp_valid=1 from the cycle after E.
- Throughput: response handshake at edge R returns to IDLE; the next accept is at edge R+1 at the earliest. The minimum op period is SETTLE_CYCLES+2 cycles.
- Simultaneous valid on both requesters during RESP or EXEC: no effect until IDLE; the grant is evaluated then.
- resp_ready held low: the block stalls in RESP indefinitely; all response outputs are frozen and busy=1.
- Reset asserted in any state (mid-EXEC or RESP): the in-flight op is discarded and no response is issued. All outputs take reset values on the next cycle.

## Test plan
- Reset, then req0 ADD a=3 b=4, SETTLE_CYCLES=1, resp_ready=1 → req0_ready=1 on the accept cycle, alu_ctrl=0010 for one cycle, then resp_valid=1 with id=0, result=7, zero=0, err=0; alu_ctrl=1111 before and after.
- req1 SUB a=9 b=9 → resp id=1, result=0, zero=1. req1 SLT a=5 b=7 → result=1, zero=0.
- req0 and req1 both held valid with two ops each (ADD 1+1, XOR F0^0F) → grants 0,1,0,1; responses in the same order with ids 0,1,0,1 and correct results (2, FF).
- req0 ctrl=0011 a=1 b=1 → resp one cycle after accept with err=1, result=0, zero=0; alu_ctrl never leaves 1111.
- SETTLE_CYCLES=3, OR a=0xA b=0x5, resp_ready low for 5 cycles → ALU ports stable for exactly 3 cycles; result 0xF held unchanged while stalled; both reqN_ready=0 and busy=1 until the handshake.
- reset pulsed during the second EXEC cycle → no resp_valid ever for that op; the next cycle shows IDLE reset values; a new req0 ADD 2+2 afterwards returns 4 and wins a tie against req1.
